// File: rtl/pipe_pkg.sv
// Shared definitions for the generic inter-stage pipeline register and its helpers.
// State encoding and default core widths used when packing stage lanes.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_e;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int WBSEL_W    = 2;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter; clear wins over increment. Reused for other perf counters.
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register: N data lanes plus a control word, valid/ready
// handshake, optional 2-entry skid, synchronous flush and a stall-cycle counter.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_DATA = 5,
    parameter int CTRL_W   = 10,
    parameter int SKID_EN  = 1,
    parameter int CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_DATA*DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0]          in_ctrl,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_DATA*DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0]          out_ctrl,
    input  logic                       cnt_clr,
    output logic [CNT_W-1:0]           stall_cnt,
    output logic [1:0]                 state_dbg
);

    localparam int LANES_W = NUM_DATA * DATA_W;

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never waits on ready, and a flush cycle drops whatever is offered.
    pipe_state_e       state_q, state_d;
    logic [LANES_W-1:0] main_data_q, main_data_d, skid_data_q;
    logic [CTRL_W-1:0]  main_ctrl_q, main_ctrl_d, skid_ctrl_q;
    logic               accept;
    logic               main_load_in, main_load_skid, main_clr;
    logic               skid_load, skid_clr;

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        main_load_in   = 1'b0;
        main_load_skid = 1'b0;
        main_clr       = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        if (flush) begin
            state_d  = ST_EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_load_in = 1'b1;
                        state_d      = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (accept && out_ready) begin
                        main_load_in = 1'b1;
                    end else if (accept && (SKID_EN != 0)) begin
                        skid_load = 1'b1;
                        state_d   = ST_SKID;
                    end else if (out_ready) begin
                        main_clr = 1'b1;
                        state_d  = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (out_ready) begin
                        main_load_skid = 1'b1;
                        skid_clr       = 1'b1;
                        state_d        = ST_FULL;
                    end
                end
                default: begin
                    state_d  = ST_EMPTY;
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end
            endcase
        end
    end

    // In skid mode in_ready depends only on the state register, never on out_ready.
    always_comb begin
        out_valid = (state_q != ST_EMPTY);
        if (SKID_EN != 0) begin
            in_ready = (state_q != ST_SKID);
        end else begin
            in_ready = (state_q == ST_EMPTY) || out_ready;
        end
    end

    always_comb begin
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        if (main_clr) begin
            main_ctrl_d = '0;
        end else if (main_load_in) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
        end else if (main_load_skid) begin
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_data_q <= '0;
            main_ctrl_q <= '0;
        end else begin
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
        end
    end

    generate
        if (SKID_EN != 0) begin : g_skid
            logic [LANES_W-1:0] skid_data_d;
            logic [CTRL_W-1:0]  skid_ctrl_d;

            always_comb begin
                skid_data_d = skid_data_q;
                skid_ctrl_d = skid_ctrl_q;
                if (skid_clr) begin
                    skid_ctrl_d = '0;
                end else if (skid_load) begin
                    skid_data_d = in_data;
                    skid_ctrl_d = in_ctrl;
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    skid_data_q <= '0;
                    skid_ctrl_q <= '0;
                end else begin
                    skid_data_q <= skid_data_d;
                    skid_ctrl_q <= skid_ctrl_d;
                end
            end
        end else begin : g_no_skid
            assign skid_data_q = '0;
            assign skid_ctrl_q = '0;
        end
    endgenerate

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (out_valid && !out_ready),
        .clr   (cnt_clr),
        .count (stall_cnt)
    );

    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q;
    assign state_dbg = state_q;

endmodule
